debounce_multi: RTL and testbench
=================================

// Module: debounce_multi
// PURPOSE
//   Parametrised multi-channel switch/button debouncer, successor to the single-channel
//   debouncer. Each of CH raw inputs has its own 4-state FSM and down-counter.
//   Outputs per channel: a debounced level, separate one-cycle rise and fall ticks, and
//   a busy flag. Sits between board-level switch pins and the user-logic control path.
// PARAMETERS
//   CH     4   number of independent channels (>=1)
//   CNT_W  2   stability counter width (>=1); M = 2**CNT_W - 1 is the load value
// PORTS
//   clk        in   1      clock, all logic on rising edge
//   reset      in   1      asynchronous, active-high; clears every channel
//   sw         in   CH     raw (bouncy) inputs, bit i = channel i
//   db_level   out  CH     debounced level, registered
//   rise_tick  out  CH     1-cycle pulse on debounced 0->1, registered
//   fall_tick  out  CH     1-cycle pulse on debounced 1->0, registered
//   busy       out  CH     channel in WAIT1 or WAIT0 (qualification in progress)
// BEHAVIOUR
//   - Reset (async, active-high): all channels go to ZERO, q=0; db_level, rise_tick,
//     fall_tick and busy are all 0. Reset mid-qualification aborts it and emits no tick.
//   - s = sampled input (sw[i] directly, or the synchroniser output, see CONFIGURATION).
//   - Per-channel FSM, one transition per clk edge:
//     ZERO : s=1 -> WAIT1, q<=M; else stay.
//     WAIT1: s=0 -> ZERO (glitch rejected, no tick); s=1 -> q<=q-1;
//            if q-1==0 -> ONE and the rise_tick register is set.
//     ONE  : s=0 -> WAIT0, q<=M; else stay.
//     WAIT0: s=1 -> ONE (glitch rejected, no tick); s=0 -> q<=q-1;
//            if q-1==0 -> ZERO and the fall_tick register is set.
//     Encodings other than the four states recover to ZERO on the next edge.
//   - Qualification requires s stable for M+1 consecutive sampled edges. db_level and the
//     tick update on that (M+1)th edge. Example: CNT_W=2 needs 4 edges.
//   - db_level = 1 in ONE and WAIT0; 0 in ZERO and WAIT1. It never changes on a rejected glitch.
//   - Ticks are high for exactly one cycle, aligned with the first cycle of the new db_level.
//     rise_tick and fall_tick are never high together on one channel.
//   - busy = 1 in WAIT1 and WAIT0, including the qualifying cycle's state.
//     busy drops in the same cycle the tick asserts.
//   - Counter arithmetic is unsigned CNT_W bits. q is never decremented below 1 in a wait
//     state, so there is no wrap-around. CNT_W=1 gives M=1 and 2-edge qualification.
//   - Channels are fully independent: simultaneous events on different channels (rise on
//     one, fall on another, both qualifying on the same edge) proceed without interaction.
// CONFIGURATION
//   DEBOUNCE_SYNC_EN defined:
//     - Each sw[i] passes through a 2-flop synchroniser (reset to 0) before the FSM.
//     - Adds exactly 2 cycles of latency to every output transition.
//   DEBOUNCE_SYNC_EN undefined:
//     - sw is sampled directly. Caller guarantees sw is synchronous to clk.
// TESTING (CH=2, CNT_W=2, macro undefined unless noted)
//   1 reset=1 with sw=2'b11 -> db_level=0, rise_tick=0, fall_tick=0, busy=0 throughout.
//   2 sw[0]=1 held 4 edges, sw[1]=0 -> db_level[0]=1 after edge 4, rise_tick[0]=1 that cycle
//     only, busy[0]=1 after edges 1-3; channel 1 outputs stay 0.
//   3 sw[0]=1 for 3 edges then 0 -> db_level[0] stays 0, no tick, busy[0] back to 0.
//   4 from ONE, sw[0]=0 held 4 edges -> db_level[0]=0 after edge 4, fall_tick[0] one cycle;
//     1-edge high glitch in WAIT0 -> stays 1, no tick.
//   5 ch0 in ONE, ch1 in ZERO, sw=2'b10 held 4 edges -> same cycle: fall_tick=2'b01,
//     rise_tick=2'b10, db_level=2'b10.
//   6 reset pulse during WAIT1 (after edge 2) -> all outputs 0, no tick. With DEBOUNCE_SYNC_EN,
//     repeat test 2 -> db_level[0] rises 2 cycles later (after edge 6).

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: per-channel 4-state FSM with a down-counter, level/tick/busy outputs.
// Optional macro DEBOUNCE_SYNC_EN inserts a 2-flop synchroniser in front of every channel.
module debounce_lane #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic s,
  output logic db_level,
  output logic rise_tick,
  output logic fall_tick,
  output logic busy
);
  typedef enum logic [1:0] {ZERO = 2'd0, WAIT1 = 2'd1, ONE = 2'd2, WAIT0 = 2'd3} state_t;

  localparam logic [CNT_W-1:0] M = '1;

  state_t           state;
  logic [CNT_W-1:0] q;
  logic [CNT_W-1:0] q_dec;

  assign q_dec = q - CNT_W'(1);

  // Outputs are registered alongside the state so they reflect the state just entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ZERO;
      q         <= '0;
      db_level  <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
      case (state)
        ZERO: if (s) begin
          state <= WAIT1;
          q     <= M;
          busy  <= 1'b1;
        end
        WAIT1: if (!s) begin
          state <= ZERO;
          busy  <= 1'b0;
        end else begin
          q <= q_dec;
          if (q_dec == '0) begin
            state     <= ONE;
            db_level  <= 1'b1;
            rise_tick <= 1'b1;
            busy      <= 1'b0;
          end
        end
        ONE: if (!s) begin
          state <= WAIT0;
          q     <= M;
          busy  <= 1'b1;
        end
        WAIT0: if (s) begin
          state <= ONE;
          busy  <= 1'b0;
        end else begin
          q <= q_dec;
          if (q_dec == '0) begin
            state     <= ZERO;
            db_level  <= 1'b0;
            fall_tick <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state    <= ZERO;
          q        <= '0;
          db_level <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end
endmodule

module debounce_multi #(
  parameter int CH    = 4,
  parameter int CNT_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db_level,
  output logic [CH-1:0] rise_tick,
  output logic [CH-1:0] fall_tick,
  output logic [CH-1:0] busy
);
  logic [CH-1:0] s;

`ifdef DEBOUNCE_SYNC_EN
  logic [CH-1:0] sync1, sync2;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw;
      sync2 <= sync1;
    end
  end
  assign s = sync2;
`else
  assign s = sw;
`endif

  for (genvar i = 0; i < CH; i++) begin : g_lane
    debounce_lane #(.CNT_W(CNT_W)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .s         (s[i]),
      .db_level  (db_level[i]),
      .rise_tick (rise_tick[i]),
      .fall_tick (fall_tick[i]),
      .busy      (busy[i])
    );
  end
endmodule

// File: tb/tb_debounce_multi.sv
// Directed-vector bench for debounce_multi (CH=2, CNT_W=2) plus a CNT_W=1 boundary instance.
module tb_debounce_multi;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sw;
  logic [1:0] db_level, rise_tick, fall_tick, busy;
  logic       sw1;
  logic       lvl1, rise1, fall1, busy1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  debounce_multi #(.CH(2), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .sw(sw),
    .db_level(db_level), .rise_tick(rise_tick), .fall_tick(fall_tick), .busy(busy)
  );

  debounce_multi #(.CH(1), .CNT_W(1)) dut1 (
    .clk(clk), .reset(reset), .sw(sw1),
    .db_level(lvl1), .rise_tick(rise1), .fall_tick(fall1), .busy(busy1)
  );

  typedef struct {
    logic       rst;
    logic [1:0] sw;
    logic [1:0] lvl, rise, fall, busy;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [1:0] s, l, ri, fa, b, input int n = 1);
    vec_t v;
    v.rst = r; v.sw = s; v.lvl = l; v.rise = ri; v.fall = fa; v.busy = b;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got lvl/rise/fall/busy=%b required %b", name, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    sw    = 2'b11;
    sw1   = 1'b0;

`ifndef DEBOUNCE_SYNC_EN
    // reset holds everything at 0 even with sw high
    add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 3);
    // ch0 rise after 4 edges
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 3);
    add(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
    add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00);
    // ch0 fall after 4 edges
    add(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 3);
    add(0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    // 3-edge pulse rejected
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 3);
    add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2);
    // back to ONE, then a 1-edge low glitch rejected in WAIT0
    add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 3);
    add(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);
    add(0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
    add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2);
    // simultaneous fall on ch0 and rise on ch1
    add(0, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11, 3);
    add(0, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00);
    add(0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00);
    // reset during ch0 WAIT1 aborts it, then both channels qualify from scratch
    add(0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 2);
    add(1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
    add(0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 3);
    add(0, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00);

    foreach (tbl[i]) begin
      reset = tbl[i].rst;
      sw    = tbl[i].sw;
      @(posedge clk); #1;
      chk($sformatf("vec%0d", i), {db_level, rise_tick, fall_tick, busy},
          {tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].busy});
    end

    // asynchronous reset clears outputs before the next edge
    reset = 1'b1;
    #2;
    chk("async_reset", {db_level, rise_tick, fall_tick, busy}, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    sw    = 2'b00;

    // CNT_W=1: two-edge qualification each way
    sw1 = 1'b1;
    @(posedge clk); #1;
    chk("w1_rise_e1", {4'h0, lvl1, rise1, fall1, busy1}, 8'b0000_0001);
    @(posedge clk); #1;
    chk("w1_rise_e2", {4'h0, lvl1, rise1, fall1, busy1}, 8'b0000_1100);
    @(posedge clk); #1;
    chk("w1_hold", {4'h0, lvl1, rise1, fall1, busy1}, 8'b0000_1000);
    sw1 = 1'b0;
    @(posedge clk); #1;
    chk("w1_fall_e1", {4'h0, lvl1, rise1, fall1, busy1}, 8'b0000_1001);
    @(posedge clk); #1;
    chk("w1_fall_e2", {4'h0, lvl1, rise1, fall1, busy1}, 8'b0000_0010);
`else
    // synchroniser adds two edges: busy after edges 3-5, rise on edge 6
    @(posedge clk); #1;
    chk("sync_reset", {db_level, rise_tick, fall_tick, busy}, 8'h00);
    reset = 1'b0;
    sw    = 2'b01;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      chk($sformatf("sync_e%0d", e), {db_level, rise_tick, fall_tick, busy},
          {1'b0, e >= 6, 1'b0, e == 6, 2'b00, 1'b0, (e >= 3 && e <= 5)});
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
